// File: rtl/timer_ctl_if.sv
// Register bus between a host and the timer_ctl block: one-cycle write
// and read strobes, 2-bit register select, 8-bit data, registered read data.
interface timer_ctl_if;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic       re;
  logic [7:0] rdata;

  modport master (output addr, output wdata, output we, output re, input rdata);
  modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/timer_ctl.sv
// Control/status front end for one timer channel. Holds the reload period,
// issues load strobes to the timer, turns rising edges of the timer's bell
// into sticky status, an expiry counter and an interrupt, and re-arms the
// timer on expiry when periodic mode is enabled.
module timer_ctl (
  input  logic       clock,
  input  logic       reset,
  timer_ctl_if.slave bus,
  output logic [7:0] value,
  input  logic       bell,
  output logic       put,
  output logic       irq
);

  logic [7:0] r_period;
  logic       r_en;
  logic       r_per;
  logic       r_ie;
  logic       r_fired;
  logic [3:0] r_ovr;
  logic [7:0] r_count;
  logic       r_bell_q;
  logic       r_put;
  logic [7:0] r_rdata;

  logic       w_fire;
  logic       w_wr_period;
  logic       w_wr_ctrl;
  logic       w_wr_status;
  logic       w_wr_count;
  logic [7:0] w_period_next;
  logic       w_en_next;
  logic       w_per_next;
  logic       w_ie_next;
  logic       w_fired_clr;
  logic       w_fired_next;
  logic [3:0] w_ovr_next;
  logic [7:0] w_count_next;
  logic       w_load;
  logic [7:0] w_rd_mux;

  assign value = r_period;
  assign put   = r_put;
  assign irq   = r_fired & r_ie;
  assign bus.rdata = r_rdata;

  // Next-state of all registers: bus writes first, then the fire event
  // layered on top so simultaneous events resolve in the fire's favour
  // except where a written value must be honoured.
  always_comb begin
    w_fire        = bell & ~r_bell_q;
    w_wr_period   = bus.we && (bus.addr == 2'd0);
    w_wr_ctrl     = bus.we && (bus.addr == 2'd1);
    w_wr_status   = bus.we && (bus.addr == 2'd2);
    w_wr_count    = bus.we && (bus.addr == 2'd3);
    w_period_next = r_period;
    w_en_next     = r_en;
    w_per_next    = r_per;
    w_ie_next     = r_ie;
    w_fired_clr   = 1'b0;
    w_fired_next  = r_fired;
    w_ovr_next    = r_ovr;
    w_count_next  = r_count;
    w_load        = 1'b0;

    if (w_wr_period) begin
      w_period_next = bus.wdata;
      w_load        = r_en;
    end
    if (w_wr_ctrl) begin
      w_load     = ~r_en & bus.wdata[0];
      w_en_next  = bus.wdata[0];
      w_per_next = bus.wdata[1];
      w_ie_next  = bus.wdata[2];
    end
    if (w_wr_status) begin
      w_fired_clr = bus.wdata[0];
      if (bus.wdata[0]) w_fired_next = 1'b0;
      if (bus.wdata[7]) w_ovr_next = 4'd0;
    end
    if (w_wr_count) begin
      w_count_next = 8'd0;
    end

    if (w_fire) begin
      w_count_next = w_count_next + 8'd1;
      if (r_fired && !w_fired_clr && (w_ovr_next != 4'hF)) begin
        w_ovr_next = w_ovr_next + 4'd1;
      end
      w_fired_next = 1'b1;
      if (w_en_next && w_per_next) begin
        w_load = 1'b1;
      end else if (w_en_next && !w_wr_ctrl) begin
        w_en_next = 1'b0;
      end
    end

    // A zero period would load a dead timer; the enable still takes effect.
    if (w_period_next == 8'd0) w_load = 1'b0;
  end

  // Read mux over pre-write register contents.
  always_comb begin
    w_rd_mux = 8'h00;
    case (bus.addr)
      2'd0: w_rd_mux = r_period;
      2'd1: w_rd_mux = {5'b0, r_ie, r_per, r_en};
      2'd2: w_rd_mux = {r_ovr, 2'b0, r_en, r_fired};
      2'd3: w_rd_mux = r_count;
      default: w_rd_mux = 8'h00;
    endcase
  end

  // State registers; reset clears everything including a pending load strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_period <= 8'd0;
      r_en     <= 1'b0;
      r_per    <= 1'b0;
      r_ie     <= 1'b0;
      r_fired  <= 1'b0;
      r_ovr    <= 4'd0;
      r_count  <= 8'd0;
      r_bell_q <= 1'b0;
      r_put    <= 1'b0;
      r_rdata  <= 8'd0;
    end else begin
      r_period <= w_period_next;
      r_en     <= w_en_next;
      r_per    <= w_per_next;
      r_ie     <= w_ie_next;
      r_fired  <= w_fired_next;
      r_ovr    <= w_ovr_next;
      r_count  <= w_count_next;
      r_bell_q <= bell;
      r_put    <= w_load;
      r_rdata  <= bus.re ? w_rd_mux : 8'h00;
    end
  end

endmodule

// File: tb/tb_timer_ctl.sv
// Bench for timer_ctl: directed scenarios with literal expectations, then
// randomized bus/bell traffic checked every cycle against a behavioural model.
module tb_timer_ctl;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       bell  = 1'b0;
  logic [7:0] value;
  logic       put;
  logic       irq;

  timer_ctl_if bus ();

  timer_ctl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .value (value),
    .bell  (bell),
    .put   (put),
    .irq   (irq)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [7:0] m_period, m_count, exp_rdata;
  logic       m_en, m_per, m_ie, m_fired, m_bell_q, exp_put;
  logic [3:0] m_ovr;

  // Literal expectation for the outputs after the current cycle's edge
  // 0 none, 1 rdata, 2 put, 3 irq
  int         lit_kind = 0;
  logic [7:0] lit_val  = 8'h00;
  bit         chk_on   = 1'b0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] view(input logic [1:0] a);
    case (a)
      2'd0: return m_period;
      2'd1: return {5'b0, m_ie, m_per, m_en};
      2'd2: return {m_ovr, 2'b0, m_en, m_fired};
      default: return m_count;
    endcase
  endfunction

  task automatic model_reset();
    m_period = 0; m_count = 0; exp_rdata = 0; m_en = 0; m_per = 0; m_ie = 0;
    m_fired = 0; m_bell_q = 0; exp_put = 0; m_ovr = 0;
  endtask

  task automatic model_step(input logic [1:0] a, input logic [7:0] d,
                            input logic w, input logic r, input logic b);
    logic fire, load, ctrl_w, fired_old, fclr;
    fire = b && !m_bell_q;
    load = 0; ctrl_w = 0; fclr = 0; fired_old = m_fired;
    exp_rdata = r ? view(a) : 8'h00;
    if (w) begin
      case (a)
        2'd0: begin m_period = d; if (m_en) load = 1; end
        2'd1: begin
          if (!m_en && d[0]) load = 1;
          m_en = d[0]; m_per = d[1]; m_ie = d[2]; ctrl_w = 1;
        end
        2'd2: begin
          fclr = d[0];
          if (d[0]) m_fired = 0;
          if (d[7]) m_ovr = 0;
        end
        default: m_count = 0;
      endcase
    end
    if (fire) begin
      m_count = m_count + 8'd1;
      if (fired_old && !fclr && m_ovr < 4'd15) m_ovr = m_ovr + 4'd1;
      m_fired = 1;
      if (m_en && m_per) load = 1;
      else if (m_en && !ctrl_w) m_en = 0;
    end
    exp_put  = load && (m_period != 8'd0);
    m_bell_q = b;
  endtask

  // Single compare process: model checks every cycle plus any literal.
  always @(negedge clock) begin
    if (chk_on) begin
      check("rdata", bus.rdata, exp_rdata);
      check("put", {7'b0, put}, {7'b0, exp_put});
      check("value", value, m_period);
      check("irq", {7'b0, irq}, {7'b0, m_fired & m_ie});
      case (lit_kind)
        1: check("lit_rdata", bus.rdata, lit_val);
        2: check("lit_put", {7'b0, put}, lit_val);
        3: check("lit_irq", {7'b0, irq}, lit_val);
        default: ;
      endcase
    end
  end

  task automatic cy(input logic [1:0] a, input logic [7:0] d, input logic w,
                    input logic r, input logic b, input int lk, input logic [7:0] lv);
    @(negedge clock); #1;
    bus.addr = a; bus.wdata = d; bus.we = w; bus.re = r; bell = b;
    lit_kind = lk; lit_val = lv;
    @(posedge clock);
    if (reset) model_step(a, d, w, r, b);
    $display("cyc a=%0d d=%02h we=%0b re=%0b bell=%0b put=%0b", a, d, w, r, b, exp_put);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input int lk, input logic [7:0] lv);
    cy(a, d, 1'b1, 1'b0, 1'b0, lk, lv);
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] lv);
    cy(a, 8'h00, 1'b0, 1'b1, 1'b0, 1, lv);
  endtask

  task automatic idle(input int lk, input logic [7:0] lv);
    cy(2'd0, 8'h00, 1'b0, 1'b0, 1'b0, lk, lv);
  endtask

  task automatic ring(input int lk, input logic [7:0] lv);
    cy(2'd0, 8'h00, 1'b0, 1'b0, 1'b1, lk, lv);
  endtask

  initial begin
    logic [1:0] ra;
    logic [7:0] rdv;
    logic       rw, rr, rb;
    bus.addr = 0; bus.wdata = 0; bus.we = 0; bus.re = 0;
    model_reset();
    chk_on = 1'b1;

    // Reset state
    repeat (3) idle(2, 8'h00);
    @(negedge clock); #3 reset = 1'b1;
    for (int i = 0; i < 4; i++) rd(2'(i), 8'h00);
    idle(3, 8'h00);

    // One-shot load and expiry
    wr(2'd0, 8'h11, 2, 8'h00);
    wr(2'd1, 8'h01, 2, 8'h01);
    idle(2, 8'h00);
    ring(2, 8'h00);
    idle(2, 8'h00);
    rd(2'd2, 8'h01);
    rd(2'd3, 8'h01);
    rd(2'd1, 8'h00);

    // Periodic reloads with overrun accounting
    wr(2'd2, 8'h81, 0, 8'h00);
    wr(2'd3, 8'h00, 0, 8'h00);
    wr(2'd1, 8'h07, 2, 8'h01);
    wr(2'd0, 8'h07, 2, 8'h01);
    idle(2, 8'h00);
    repeat (3) begin
      ring(2, 8'h01);
      idle(2, 8'h00);
    end
    rd(2'd3, 8'h03);
    rd(2'd2, 8'h23);
    idle(3, 8'h01);
    wr(2'd2, 8'h81, 3, 8'h00);
    rd(2'd2, 8'h02);

    // Fire coinciding with W1C, then a long bell level
    ring(0, 8'h00);
    idle(0, 8'h00);
    cy(2'd2, 8'h01, 1'b1, 1'b0, 1'b1, 0, 8'h00);
    idle(0, 8'h00);
    rd(2'd2, 8'h03);
    wr(2'd3, 8'h00, 0, 8'h00);
    repeat (10) ring(0, 8'h00);
    idle(0, 8'h00);
    rd(2'd3, 8'h01);

    // Zero period suppresses loads; counter wrap and overrun saturation
    wr(2'd2, 8'h81, 0, 8'h00);
    wr(2'd3, 8'h00, 0, 8'h00);
    wr(2'd1, 8'h00, 0, 8'h00);
    wr(2'd0, 8'h00, 0, 8'h00);
    wr(2'd1, 8'h07, 2, 8'h00);
    rd(2'd2, 8'h02);
    repeat (257) begin
      ring(2, 8'h00);
      idle(0, 8'h00);
    end
    rd(2'd3, 8'h01);
    rd(2'd2, 8'hF3);
    idle(3, 8'h01);

    // Reset while a reload strobe is pending
    wr(2'd0, 8'h22, 2, 8'h01);
    idle(0, 8'h00);
    cy(2'd3, 8'h00, 1'b0, 1'b1, 1'b1, 1, 8'h00);
    #2 reset = 1'b0;
    model_reset();
    idle(2, 8'h00);
    idle(3, 8'h00);
    @(negedge clock); #3 reset = 1'b1;
    for (int i = 0; i < 4; i++) rd(2'(i), 8'h00);

    // Randomized traffic
    rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      ra  = 2'($urandom_range(0, 3));
      rdv = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      rw  = ($urandom_range(0, 9) < 3);
      rr  = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      cy(ra, rdv, rw, rr, rb, 0, 8'h00);
    end

    @(negedge clock); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
